// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a per-register pending bit and a sequenced
// clear engine that zeroes entries 1..NREG-1, one per cycle, after reset or on request.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_start,
  output logic            busy,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            pend1,
  output logic            pend2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            res_en,
  input  logic [AW-1:0]   res_addr,
  output logic            dbg_state_o,
  output logic [AW-1:0]   dbg_idx_o
);

  localparam int unsigned NREG     = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;

  logic clr_go;
  logic mem_clr;
  logic wr_en;
  logic res_ok;

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      idx_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          idx_d   = FIRST_IDX;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + FIRST_IDX;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q == S_CLEAR);
    mem_clr = (state_q == S_CLEAR);
    clr_go  = (state_q == S_IDLE) && clr_start;
  end

  assign dbg_state_o = state_q;
  assign dbg_idx_o   = idx_q;

  // ---------------------------------------------------------------------------
  // Storage: no reset; the sequencer is the only thing that zeroes it
  // ---------------------------------------------------------------------------
  assign wr_en  = we && !busy && (wa != '0);
  assign res_ok = res_en && !busy && (res_addr != '0);

  always_ff @(posedge clk) begin
    if (mem_clr) begin
      mem_q[idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits: a release and a reservation to the same register leave it set,
  // because the reservation belongs to the newer instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    if (clr_go) begin
      pend_d = '0;
    end else begin
      if (wr_en) begin
        pend_d[wa] = 1'b0;
      end
      if (res_ok) begin
        pend_d[res_addr] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd1_data = '0;
    pend1    = 1'b0;
    if ((rs1_addr != '0) && !busy) begin
      if ((BYPASS != 0) && we && (wa == rs1_addr)) begin
        rd1_data = wd;
      end else begin
        rd1_data = mem_q[rs1_addr];
      end
      pend1 = pend_q[rs1_addr];
      if ((BYPASS != 0) && we && (wa == rs1_addr) && !(res_en && (res_addr == rs1_addr))) begin
        pend1 = 1'b0;
      end
    end
  end

  always_comb begin
    rd2_data = '0;
    pend2    = 1'b0;
    if ((rs2_addr != '0) && !busy) begin
      if ((BYPASS != 0) && we && (wa == rs2_addr)) begin
        rd2_data = wd;
      end else begin
        rd2_data = mem_q[rs2_addr];
      end
      pend2 = pend_q[rs2_addr];
      if ((BYPASS != 0) && we && (wa == rs2_addr) && !(res_en && (res_addr == rs2_addr))) begin
        pend2 = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_pend0_zero: assert property (@(posedge clk) disable iff (!rst_n) pend_q[0] == 1'b0);
  a_idx_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_CLEAR) |-> (idx_q != '0));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed sequences plus random traffic, with a
// behavioural model feeding an expected-response queue drained by a monitor.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NREG   = 1 << AW;
  localparam int BYPASS = 1;
  localparam int EW     = 1 + 2 * XLEN + 2;

  logic            clk;
  logic            rst_n;
  logic            clr_start;
  logic            busy;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rd1_data, rd2_data;
  logic            pend1, pend2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            res_en;
  logic [AW-1:0]   res_addr;
  logic            dbg_state;
  logic [AW-1:0]   dbg_idx;

  regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_start  (clr_start),
    .busy       (busy),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd1_data   (rd1_data),
    .rd2_data   (rd2_data),
    .pend1      (pend1),
    .pend2      (pend2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .res_en     (res_en),
    .res_addr   (res_addr),
    .dbg_state_o(dbg_state),
    .dbg_idx_o  (dbg_idx)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend [NREG];
  int              m_clear_left;

  logic [EW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_clear_left = NREG - 1;
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0 || m_clear_left > 0) return '0;
    if (BYPASS != 0 && we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic exp_pd(input logic [AW-1:0] a);
    if (a == 0 || m_clear_left > 0) return 1'b0;
    if (BYPASS != 0 && we && wa == a && !(res_en && res_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (res_en && res_addr != 0) m_pend[res_addr] = 1'b1;
      if (clr_start) begin
        for (int i = 0; i < NREG; i++) begin
          m_mem[i]  = '0;
          m_pend[i] = 1'b0;
        end
        m_clear_left = NREG - 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [EW-1:0] e;
    if (!rst_n) model_reset();
    e = {(m_clear_left > 0), exp_rd(rs1_addr), exp_rd(rs2_addr),
         exp_pd(rs1_addr), exp_pd(rs2_addr)};
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drv(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                     input logic r, input logic [AW-1:0] ra,
                     input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic cs);
    we = w; wa = a; wd = d;
    res_en = r; res_addr = ra;
    rs1_addr = r1; rs2_addr = r2;
    clr_start = cs;
    step();
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drv(1'b0, '0, '0, 1'b0, '0, r1, r2, 1'b0);
  endtask

  task automatic rand_cycle(input logic allow_clr);
    logic [AW-1:0] a, ra, r1, r2;
    a  = AW'($urandom_range(0, NREG - 1));
    ra = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, NREG - 1));
    r1 = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, NREG - 1));
    r2 = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, NREG - 1));
    drv(($urandom_range(0, 1) == 1), a, $urandom, ($urandom_range(0, 2) == 0), ra, r1, r2,
        allow_clr && ($urandom_range(0, 59) == 0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t rs1=%0d rs2=%0d)",
               name, got, expv, $time, rs1_addr, rs2_addr);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("busy",  XLEN'(busy),  XLEN'(e[EW-1]));
      check("rd1",   rd1_data,     e[EW-2 -: XLEN]);
      check("rd2",   rd2_data,     e[XLEN+1 -: XLEN]);
      check("pend1", XLEN'(pend1), XLEN'(e[1]));
      check("pend2", XLEN'(pend2), XLEN'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    res_en = 1'b0; res_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
    clr_start = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // reset, then the post-reset clear and reads of every entry
    rst_n = 1'b0;
    idle(AW'(1), AW'(2));
    idle(AW'(3), AW'(4));
    rst_n = 1'b1;
    for (int i = 0; i < NREG - 1; i++) idle(AW'(i + 1), AW'(i + 1));
    for (int i = 1; i < NREG; i++) idle(AW'(i), AW'(NREG - i));

    // write then read; write to x0 discarded
    drv(1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, '0, '0, 1'b0);
    idle(AW'(5), AW'(5));
    drv(1'b1, AW'(0), 32'h00001234, 1'b0, '0, '0, '0, 1'b0);
    idle(AW'(5), AW'(0));

    // same-cycle bypass
    drv(1'b1, AW'(7), 32'hA5A5A5A5, 1'b0, '0, AW'(5), AW'(7), 1'b0);
    idle(AW'(7), AW'(7));

    // pending set, release, simultaneous release + reserve
    drv(1'b0, '0, '0, 1'b1, AW'(3), AW'(3), AW'(3), 1'b0);
    idle(AW'(3), AW'(3));
    drv(1'b1, AW'(3), 32'h33333333, 1'b0, '0, AW'(3), AW'(3), 1'b0);
    idle(AW'(3), AW'(3));
    drv(1'b1, AW'(3), 32'h44444444, 1'b1, AW'(3), AW'(3), AW'(3), 1'b0);
    idle(AW'(3), AW'(3));
    drv(1'b0, '0, '0, 1'b1, AW'(3), AW'(3), AW'(0), 1'b0);
    idle(AW'(3), AW'(3));

    // fill, reserve a few, clear with traffic during busy, read everything back
    for (int i = 1; i < NREG; i++) drv(1'b1, AW'(i), XLEN'(i), 1'b1, AW'(NREG - i), AW'(i), '0, 1'b0);
    idle(AW'(9), AW'(10));
    drv(1'b0, '0, '0, 1'b0, '0, AW'(9), AW'(10), 1'b1);
    for (int i = 0; i < NREG - 1; i++) rand_cycle(1'b1);
    for (int i = 1; i < NREG; i++) idle(AW'(i), AW'(i));

    // reset at clear cycle 10 restarts the full sequence
    drv(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) rand_cycle(1'b0);
    rst_n = 1'b0;
    idle(AW'(1), AW'(2));
    idle(AW'(1), AW'(2));
    rst_n = 1'b1;
    for (int i = 0; i < NREG + 1; i++) idle(AW'(i % NREG), AW'((i + 3) % NREG));

    // random traffic with occasional clears
    for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
    idle('0, '0);

    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
